// File: rtl/ram_arbiter_pkg.sv
// Shared constants and types for the two-requester RAM arbiter.
package ram_arbiter_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 3;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    ARB   = 1'b1
  } state_t;

  typedef logic req_id_t;
endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: a lone request wins, a tie goes
// to the requester that was not granted most recently.
module rr_arb2
  import ram_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last,
  output logic [1:0] gnt,
  output req_id_t    winner
);

  always_comb begin
    winner = 1'b0;
    unique case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last;
      default: winner = 1'b0;
    endcase
    gnt[0] = (|req) & ~winner;
    gnt[1] = (|req) & winner;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Owns a 32x3 single-port RAM: zero-fills it after reset or on clear, then
// shares the port between two requesters with round-robin arbitration.
module ram_arbiter
  import ram_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  output logic              busy,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output state_t            dbg_state
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  req_id_t           r_last;
  logic              r_rvalid0;
  logic              r_rvalid1;

  state_t            w_state_nxt;
  logic [ADDR_W-1:0] w_cnt_nxt;
  req_id_t           w_last_nxt;
  logic [1:0]        w_arb_gnt;
  req_id_t           w_winner;
  logic [1:0]        w_gnt;

  rr_arb2 u_rr_arb2 (
    .req    ({req1, req0}),
    .last   (r_last),
    .gnt    (w_arb_gnt),
    .winner (w_winner)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_gnt       = 2'b00;
    busy        = 1'b0;
    ram_address = '0;
    ram_data    = '0;
    ram_wren    = 1'b0;
    unique case (r_state)
      CLEAR: begin
        // clear is deliberately not looked at here: a running fill is never restarted
        busy        = 1'b1;
        ram_address = r_cnt;
        ram_wren    = 1'b1;
        if (r_cnt == ADDR_W'(DEPTH - 1)) begin
          w_state_nxt = ARB;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ARB: begin
        if (clear) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = '0;
        end else begin
          w_gnt = w_arb_gnt;
          if (w_gnt[1]) begin
            ram_address = addr1;
            ram_data    = wdata1;
            ram_wren    = we1;
          end else if (w_gnt[0]) begin
            ram_address = addr0;
            ram_data    = wdata0;
            ram_wren    = we0;
          end
        end
      end
      default: begin
        w_state_nxt = CLEAR;
        w_cnt_nxt   = '0;
      end
    endcase
    w_last_nxt = (|w_gnt) ? w_winner : r_last;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= CLEAR;
      r_cnt     <= '0;
      r_last    <= 1'b1;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_last    <= w_last_nxt;
      r_rvalid0 <= w_gnt[0] & ~we0;
      r_rvalid1 <= w_gnt[1] & ~we1;
    end
  end

  assign gnt0      = w_gnt[0];
  assign gnt1      = w_gnt[1];
  assign rvalid0   = r_rvalid0;
  assign rvalid1   = r_rvalid1;
  assign rdata0    = ram_q;
  assign rdata1    = ram_q;
  assign dbg_state = r_state;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester controller for the 32×3 single-port synchronous-read RAM on the DE1_SoC board. It owns the RAM's address, data and write-enable lines. After reset, or on request, it clears the whole array to zero. It then shares the port between requester 0 and requester 1 using round-robin arbitration, and returns read data with a per-requester valid strobe.

## Interface
- ADDR_W, 5, RAM address width
- DATA_W, 3, RAM word width
- DEPTH, 32, number of words; always 2**ADDR_W
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- clear  in  1  one-cycle pulse that starts a full zero-fill of the RAM
- busy  out  1  high while the zero-fill runs
- req0 / req1  in  1  requester access request; held until granted
- we0 / we1  in  1  1 = write, 0 = read; valid with req
- addr0 / addr1  in  ADDR_W  access address; valid with req
- wdata0 / wdata1  in  DATA_W  write data; valid with req
- gnt0 / gnt1  out  1  access issued to the RAM this cycle (combinational)
- rvalid0 / rvalid1  out  1  read data valid for this requester (registered)
- rdata0 / rdata1  out  DATA_W  read data; both carry ram_q
- ram_address  out  ADDR_W  to RAM address
- ram_data  out  DATA_W  to RAM write data
- ram_wren  out  1  to RAM write enable
- ram_q  in  DATA_W  from RAM; registered read, 1-cycle latency

## Operation
- States:
  - CLEAR: walks the 5-bit counter cnt through 0..31.
    - ram_address = cnt, ram_data = 0, ram_wren = 1, busy = 1.
    - gnt0 = gnt1 = 0.
    - Moves to ARB after the write with cnt = 31; cnt returns to 0.
  - ARB: arbitrates between the two requesters.
    - With no grant: ram_wren = 0, ram_address = 0, ram_data = 0.
- Arbitration in ARB when clear = 0:
  - Only one req high: that requester is granted.
  - Both high: the requester not granted most recently wins.
  - Pointer `last` updates to the granted requester on every grant.
- On a grant: ram_address, ram_data and ram_wren take addrX, wdataX and weX.
- clear = 1 in ARB:
  - No grant is given that cycle.
  - Next state is CLEAR with cnt = 0.
  - Pending requests stay pending.
- clear is ignored while in CLEAR; the fill is not restarted.
- At most one grant per cycle; gnt0 and gnt1 are never both 1.

## Timing
- Reset (reset = 0) values:
  - state = CLEAR, cnt = 0, last = 1 (requester 0 wins the first tie).
  - rvalid0 = rvalid1 = 0, busy = 1.
  - ram_wren = 1, ram_address = 0, ram_data = 0; repeatedly writing 0 to address 0 is idempotent.
- Clear duration: exactly 32 clock edges after reset release or after the clear edge. busy falls on the 32nd edge, and grants are possible in that same following cycle.
- Grants are combinational, in the same cycle as req.
- A requester drops or changes req only after the edge that ends a gnt cycle.
- Read latency: a read granted in cycle N gives rvalidX = 1 in cycle N+1 with rdataX = ram_q, for exactly one cycle.
- Writes produce no rvalid.
- A write granted in cycle N is visible to a read granted in cycle N+1 or later.
- rvalid clears on the clear edge, so it is never asserted in the first CLEAR cycle after a final ARB read. The read issued in the last ARB cycle still returns its rvalid.
- Asynchronous reset mid-clear or mid-read aborts immediately. Any in-flight rvalid is dropped, and the fill restarts from address 0 after release.

## Structure
- Package ram_arbiter_pkg holds:
  - ADDR_W, DATA_W, DEPTH constants.
  - state_t enum {CLEAR, ARB}.
  - req_id_t (1-bit requester index).
- Sub-module rr_arb2 is the combinational two-way round-robin pick. Inputs: req[1:0], last. Outputs: gnt[1:0], winner.
- Pointer, counter and rvalid registers live in ram_arbiter.

## Test plan
- Reset release → busy high for 32 cycles, ram_wren = 1 with addresses 0..31 and data 0. Then busy = 0; a read of address 17 by requester 0 returns rdata0 = 0 with rvalid0 one cycle after gnt0.
- Requester 1 writes 5 to address 3, then requester 0 reads address 3 the next cycle → rvalid0 = 1 with rdata0 = 5; rvalid1 stays 0.
- req0 and req1 held together for 4 cycles, starting fresh after reset → grant order 0, 1, 0, 1; never both granted in one cycle.
- Write 7 to address 31, pulse clear while req1 is high → no grant that cycle, busy for 32 cycles, req1 granted after busy falls. A read of address 31 then returns 0.
- reset asserted at cnt = 10 during a clear, or one cycle after a read grant → rvalid immediately 0 and busy = 1. After release the clear restarts at address 0 and lasts 32 cycles.
